// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic master bridging a valid/ready command port
// to a valid/ready response port, with a per-transaction STB timeout.
module wb_host_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_tmo_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_tmo_q, rsp_tmo_d;
    logic [31:0] cnt_inc;

    assign cnt_inc = 32'(cnt_q) + 32'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        rsp_tmo_d = rsp_tmo_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_we_i ? cmd_dat_i : 32'd0;
                    sel_d   = cmd_sel_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                // ERR outranks ACK; either outranks a timeout landing in the same cycle.
                if (wbm_err_i) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = 32'd0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b0;
                    state_d   = StResp;
                end else if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = we_q ? 32'd0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    rsp_tmo_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_inc >= TIMEOUT) begin
                    cyc_d     = 1'b0;
                    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_inc[15:0];
                    rsp_dat_d = 32'd0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_inc[15:0];
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            rsp_tmo_q <= rsp_tmo_d;
        end
    end

    assign cmd_ready_o = (state_q == StIdle) && !wb_rst_i;
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_tmo_o   = rsp_tmo_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Directed, table-driven bench for wb_host_master with TIMEOUT=4 and a scripted slave.
module tb_wb_host_master;

    localparam int unsigned Tmo = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err, rsp_tmo;
    logic        cyc, stb, we;
    logic [31:0] adr, dato;
    logic [3:0]  sel;
    logic        ack, err;
    logic [31:0] dati;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_host_master #(.TIMEOUT(Tmo)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_we_i   (cmd_we),
        .cmd_adr_i  (cmd_adr),
        .cmd_dat_i  (cmd_dat),
        .cmd_sel_i  (cmd_sel),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_dat_o  (rsp_dat),
        .rsp_err_o  (rsp_err),
        .rsp_tmo_o  (rsp_tmo),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dato),
        .wbm_sel_o  (sel),
        .wbm_ack_i  (ack),
        .wbm_err_i  (err),
        .wbm_dat_i  (dati)
    );

    // kind: 0 = ACK, 1 = ERR, 2 = ACK+ERR, 3 = silent slave
    typedef struct {
        bit        we;
        bit [31:0] adr;
        bit [31:0] dat;
        bit [3:0]  sel;
        int        delay;
        int        kind;
        bit [31:0] sdat;
        bit [31:0] exp_dat;
        bit        exp_err;
        bit        exp_tmo;
        int        exp_stb;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          n;
        bit          done;
        logic [31:0] exp_wdat;
        exp_wdat = v.we ? v.dat : 32'd0;
        @(negedge clk);
        chk($sformatf("v%0d cmd_ready idle", idx), {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = 32'hFFFF_FFFF;
        cmd_dat   = 32'hFFFF_FFFF;
        n    = 0;
        done = 1'b0;
        for (int it = 0; it < 20 && !done; it++) begin
            ack = 1'b0;
            err = 1'b0;
            if (stb) begin
                n++;
                if (cyc !== stb || adr !== v.adr || we !== v.we || sel !== v.sel
                    || dato !== exp_wdat || cmd_ready !== 1'b0) begin
                    chk($sformatf("v%0d bus fields", idx),
                        {cyc, we, cmd_ready, sel, adr[24:0]},
                        {1'b1, v.we, 1'b0, v.sel, v.adr[24:0]});
                end
                if (v.kind != 3 && n == v.delay + 1) begin
                    ack  = (v.kind == 0 || v.kind == 2);
                    err  = (v.kind == 1 || v.kind == 2);
                    dati = v.sdat;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        chk($sformatf("v%0d bus ended", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d stb cycles", idx), n, v.exp_stb);
        chk($sformatf("v%0d rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
        chk($sformatf("v%0d rsp_dat", idx), rsp_dat, v.exp_dat);
        chk($sformatf("v%0d rsp_err/tmo", idx), {30'd0, rsp_err, rsp_tmo},
            {30'd0, v.exp_err, v.exp_tmo});
        // Late ACK/ERR while waiting in RESP must be ignored.
        ack  = 1'b1;
        err  = 1'b1;
        dati = 32'hA5A5_A5A5;
        @(negedge clk);
        ack = 1'b0;
        err = 1'b0;
        chk($sformatf("v%0d late ack ignored", idx),
            {28'd0, rsp_valid, rsp_err, rsp_tmo, stb}, {28'd0, 1'b1, v.exp_err, v.exp_tmo, 1'b0});
        chk($sformatf("v%0d rsp_dat stable", idx), rsp_dat, v.exp_dat);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d after handshake", idx), {30'd0, rsp_valid, cmd_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] hold_dat;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; ack = 1'b0; err = 1'b0; dati = '0;

        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 0, 32'hFFFF_FFFF,
                    32'd0, 1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 32'h3000_0000, 32'h1111_1111, 4'hF, 0, 0, 32'h1234_5678,
                    32'h1234_5678, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D,
                    32'd0, 1'b1, 1'b0, 2};
        vecs[3] = '{1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 3, 32'h0,
                    32'd0, 1'b1, 1'b1, Tmo};
        vecs[4] = '{1'b0, 32'h4000_0010, 32'h0, 4'h3, 0, 1, 32'h5555_5555,
                    32'd0, 1'b1, 1'b0, 1};
        vecs[5] = '{1'b0, 32'h4000_0020, 32'h0, 4'hC, 3, 0, 32'h8765_4321,
                    32'h8765_4321, 1'b0, 1'b0, 4};
        vecs[6] = '{1'b1, 32'h5000_0000, 32'h0BAD_CAFE, 4'h1, 1, 1, 32'h0,
                    32'd0, 1'b1, 1'b0, 2};

        repeat (2) @(negedge clk);
        chk("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("reset ctrl", {26'd0, cyc, stb, we, rsp_valid, rsp_err, rsp_tmo}, 32'd0);
        chk("reset adr", adr, 32'd0);
        chk("reset dat/sel", dato | rsp_dat | {28'd0, sel}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Response backpressure with a pending command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h6000_0000; cmd_sel = 4'hF;
        @(negedge clk);
        chk("bp stb", {31'd0, stb}, 32'd1);
        ack = 1'b1; dati = 32'h0F0F_0F0F; cmd_adr = 32'h6000_0004;
        @(negedge clk);
        ack = 1'b0;
        hold_dat = 32'h0F0F_0F0F;
        for (int c = 0; c < 10; c++) begin
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== hold_dat
                || rsp_err !== 1'b0 || stb !== 1'b0)
                chk($sformatf("bp hold c%0d", c), {27'd0, cmd_ready, rsp_valid, rsp_err, stb, 1'b0},
                    {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
            else n_cmp++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp ready after handshake", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp next accepted", {31'd0, stb}, 32'd1);
        chk("bp next adr", adr, 32'h6000_0004);
        ack = 1'b1; dati = 32'h7777_0000;
        @(negedge clk);
        ack = 1'b0;
        chk("bp next rsp", rsp_dat, 32'h7777_0000);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset pulse mid-BUS discards the transaction.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h7000_0000; cmd_dat = 32'h1234_0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst bus stb", {31'd0, stb}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst cmd_ready low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst drop", {29'd0, cyc, stb, rsp_valid}, 32'd0);
        chk("rst adr cleared", adr, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst no rsp", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        run_vec(vecs[1], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_host_master.md
WB_HOST_MASTER -- requirements
Module: wb_host_master

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles STB held without ACK/ERR before abort; legal 1..65535.
REQ-002 wb_clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid_i  input  1  command offered.
REQ-005 cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o.
REQ-006 cmd_we_i  input  1  1 = write, 0 = read.
REQ-007 cmd_adr_i  input  32  byte address.
REQ-008 cmd_dat_i  input  32  write data.
REQ-009 cmd_sel_i  input  4  byte enables.
REQ-010 rsp_valid_o  output  1  response available.
REQ-011 rsp_ready_i  input  1  response consumed when rsp_valid_o && rsp_ready_i.
REQ-012 rsp_dat_o  output  32  read data (0 for writes and for failed reads).
REQ-013 rsp_err_o  output  1  1 = slave ERR or timeout.
REQ-014 rsp_tmo_o  output  1  1 = timeout abort (implies rsp_err_o).
REQ-015 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-016 wbm_adr_o  output  32;  wbm_dat_o  output  32;  wbm_sel_o  output  4.
REQ-017 wbm_ack_i, wbm_err_i  input  1 each;  wbm_dat_i  input  32.

Function
REQ-018 FSM states IDLE, BUS, RESP; exactly one transaction outstanding at a time.
REQ-019 IDLE: cmd_ready_o=1; on accept, register we/adr/dat/sel into wbm_* outputs, assert wbm_cyc_o=wbm_stb_o=1 from next cycle, go BUS.
REQ-020 cmd_ready_o SHALL be 0 in BUS and RESP.
REQ-021 BUS: wbm_adr_o/dat_o/sel_o/we_o held stable while stb high; wbm_dat_o SHALL be 0 for reads.
REQ-022 BUS, wbm_ack_i=1 sampled: drop cyc/stb next cycle, capture wbm_dat_i (reads only), rsp_err_o=0, go RESP.
REQ-023 BUS, wbm_err_i=1 sampled: drop cyc/stb, rsp_dat_o=0, rsp_err_o=1, rsp_tmo_o=0, go RESP; ERR wins if ACK and ERR both high.
REQ-024 Timeout counter cleared on entering BUS, increments each BUS cycle without ACK/ERR; on reaching TIMEOUT, drop cyc/stb, rsp_err_o=1, rsp_tmo_o=1, rsp_dat_o=0, go RESP.
REQ-025 ACK/ERR in the same cycle the counter reaches TIMEOUT SHALL be honoured as normal completion, not timeout.
REQ-026 Counter SHALL saturate, never wrap; ACK/ERR arriving outside BUS SHALL be ignored.
REQ-027 RESP: rsp_valid_o=1, rsp_* stable until rsp_ready_i; on handshake return IDLE, rsp_valid_o=0 next cycle.
REQ-028 Minimum latency: accept at edge N, stb high N+1, ACK at N+1 -> rsp_valid_o high N+2; back-to-back command accepted earliest cycle after response handshake.
REQ-029 wbm_cyc_o and wbm_stb_o SHALL always be equal (single classic cycles, no bursts, no pipelining).

Reset
REQ-030 wb_rst_i=1 at a clock edge: state IDLE, counter 0; wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid_o, rsp_err_o, rsp_tmo_o = 0; wbm_adr_o, wbm_dat_o, rsp_dat_o = 0; wbm_sel_o = 0.
REQ-031 Reset mid-BUS SHALL drop cyc/stb the following cycle and discard the transaction with no response; cmd_ready_o=0 while wb_rst_i is high.

Verification
REQ-032 Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, slave ACKs after 2 cycles -> wbm_we_o=1, bus fields stable, rsp_valid_o with err=0, dat=0.
REQ-033 Read adr=0x3000_0000, slave ACKs with 0x1234_5678 same cycle stb rises -> rsp_dat_o=0x1234_5678, rsp_valid_o 2 cycles after accept.
REQ-034 Read, slave asserts ERR and ACK together -> rsp_err_o=1, rsp_tmo_o=0, rsp_dat_o=0.
REQ-035 TIMEOUT=4, slave silent -> cyc/stb drop after 4 stb cycles, rsp_err_o=1, rsp_tmo_o=1; late ACK ignored.
REQ-036 rsp_ready_i held 0 for 10 cycles while cmd_valid_i=1 -> cmd_ready_o=0, rsp_* stable throughout; next command accepted cycle after handshake.
REQ-037 wb_rst_i pulsed during BUS -> cyc/stb=0 next cycle, no rsp_valid_o, subsequent command completes normally.
